// File: rtl/systolic_tile_feeder.sv
// Tile buffer and sequencer feeding the systolic skew stage: loads a LENGTH x LENGTH tile, then streams it plus LENGTH-1 zero vectors.
// Define TRANSPOSE_EN to stream columns instead of rows (weight-stationary layout).
module systolic_tile_feeder #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 5
) (
    input  logic                              CLK,
    input  logic                              ASYNC_RST,
    input  logic                              SYNC_RST,
    input  logic                              In_Valid,
    output logic                              In_Ready,
    input  logic [0:LENGTH-1][WIDTH-1:0]      In_Data,
    input  logic                              Hold,
    output logic [0:LENGTH-1][WIDTH-1:0]      Outputs,
    output logic                              Out_EN,
    output logic                              Busy,
    output logic                              Done
);

    localparam int CW = $clog2(LENGTH) + 1;
    localparam int IW = $clog2(LENGTH);
    localparam logic [CW-1:0] LAST_ROW   = CW'(LENGTH - 1);
    localparam logic [CW-1:0] LAST_FLUSH = CW'(LENGTH - 2);

    typedef enum logic [1:0] {LOAD, DRAIN, FLUSH, DONE} state_t;

    state_t                         state;
    logic [CW-1:0]                  cnt;
    logic [IW-1:0]                  idx;
    logic                           beat_acc;
    logic [0:LENGTH-1][WIDTH-1:0]   tile_buf [0:LENGTH-1];
    logic [0:LENGTH-1][WIDTH-1:0]   drain_vec;

    assign In_Ready = (state == LOAD);
    assign idx      = cnt[IW-1:0];
    // A synchronous reset on the same edge drops the beat.
    assign beat_acc = In_Valid && In_Ready && !SYNC_RST;

    // Tile storage holds data only, so it is never cleared.
    always_ff @(posedge CLK) begin
        if (beat_acc) begin
            tile_buf[idx] <= In_Data;
        end
    end

    always_comb begin
        drain_vec = '0;
`ifdef TRANSPOSE_EN
        for (int i = 0; i < LENGTH; i++) begin
            drain_vec[i] = tile_buf[i][idx];
        end
`else
        drain_vec = tile_buf[idx];
`endif
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state   <= LOAD;
            cnt     <= '0;
            Outputs <= '0;
            Out_EN  <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else if (SYNC_RST) begin
            state   <= LOAD;
            cnt     <= '0;
            Outputs <= '0;
            Out_EN  <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (In_Valid) begin
                        if (cnt == LAST_ROW) begin
                            state <= DRAIN;
                            cnt   <= '0;
                            Busy  <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (Hold) begin
                        Out_EN <= 1'b0;
                    end else begin
                        Outputs <= drain_vec;
                        Out_EN  <= 1'b1;
                        if (cnt == LAST_ROW) begin
                            state <= FLUSH;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (Hold) begin
                        Out_EN <= 1'b0;
                    end else begin
                        Outputs <= '0;
                        Out_EN  <= 1'b1;
                        if (cnt == LAST_FLUSH) begin
                            state <= DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    // First edge raises the Done pulse, second returns to LOAD.
                    Out_EN  <= 1'b0;
                    Outputs <= '0;
                    if (!Done) begin
                        Done <= 1'b1;
                    end else begin
                        Done  <= 1'b0;
                        Busy  <= 1'b0;
                        cnt   <= '0;
                        state <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_tile_feeder.sv
// Bench for systolic_tile_feeder: table of tile scenarios plus hand-written reset sequences, checked against a queue scoreboard.
module tb_systolic_tile_feeder;

    localparam int WIDTH  = 8;
    localparam int LENGTH = 5;

    typedef logic [0:LENGTH-1][WIDTH-1:0] vec_t;

    typedef struct {
        bit throttle;
        int hold_after;
        int hold_len;
        bit junk;
        int base;
        int exp_done;
    } tcase_t;

    logic CLK = 1'b0;
    logic ASYNC_RST, SYNC_RST, In_Valid, In_Ready, Hold, Out_EN, Busy, Done;
    vec_t In_Data, Outputs;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t exp_q[$];
    vec_t last_vec;
    tcase_t tc[4];

    always #5 CLK = ~CLK;

    systolic_tile_feeder #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .CLK      (CLK),
        .ASYNC_RST(ASYNC_RST),
        .SYNC_RST (SYNC_RST),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .In_Data  (In_Data),
        .Hold     (Hold),
        .Outputs  (Outputs),
        .Out_EN   (Out_EN),
        .Busy     (Busy),
        .Done     (Done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t row_vec(input int base, input int r);
        vec_t v;
        for (int c = 0; c < LENGTH; c++) v[c] = WIDTH'(base + 10*r + c);
        return v;
    endfunction

    function automatic vec_t exp_vec(input int base, input int k);
        vec_t v;
`ifdef TRANSPOSE_EN
        for (int i = 0; i < LENGTH; i++) v[i] = WIDTH'(base + 10*i + k);
`else
        v = row_vec(base, k);
`endif
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pop_check(input string name);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %0h expected nothing (scoreboard empty)", name, Outputs);
        end else begin
            e = exp_q.pop_front();
            chk(name, Outputs, e);
            last_vec = e;
        end
    endtask

    task automatic load_tile(input int base, input bit throttle);
        for (int r = 0; r < LENGTH; r++) begin
            In_Valid = 1'b1;
            In_Data  = row_vec(base, r);
            chk("in_ready_load", In_Ready, 1);
            step();
            if (throttle && r < LENGTH-1) begin
                In_Valid = 1'b0;
                In_Data  = '1;
                chk("in_ready_idle", In_Ready, 1);
                step();
            end
        end
        In_Valid = 1'b0;
        for (int k = 0; k < LENGTH; k++) exp_q.push_back(exp_vec(base, k));
        for (int k = 0; k < LENGTH-1; k++) exp_q.push_back('0);
    endtask

    task automatic drain_check(input int hold_after, input int hold_len, input int exp_done, input bit junk);
        int en_cnt;
        en_cnt = 0;
        chk("busy_after_load", Busy, 1);
        chk("in_ready_after_load", In_Ready, 0);
        if (junk) begin
            In_Valid = 1'b1;
            In_Data  = '1;
        end
        for (int t = 1; t <= exp_done + 1; t++) begin
            bit held;
            bit exp_en;
            held   = (t > hold_after) && (t <= hold_after + hold_len);
            exp_en = (t < exp_done) && !held;
            Hold   = held;
            step();
            chk("out_en", Out_EN, exp_en);
            if (Out_EN) en_cnt++;
            if (exp_en) pop_check("data");
            else if (held) chk("held_data", Outputs, last_vec);
            else chk("zero_out", Outputs, 0);
            chk("done", Done, t == exp_done);
            chk("busy", Busy, t <= exp_done);
            chk("in_ready", In_Ready, t > exp_done);
        end
        Hold     = 1'b0;
        In_Valid = 1'b0;
        chk("en_total", en_cnt, 2*LENGTH-1);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tc[0] = '{1'b0, 0, 0, 1'b0, 0,   10};
        tc[1] = '{1'b1, 0, 0, 1'b0, 50,  10};
        tc[2] = '{1'b0, 2, 3, 1'b0, 7,   13};
        tc[3] = '{1'b0, 0, 0, 1'b1, 200, 10};

        ASYNC_RST = 1'b0;
        SYNC_RST  = 1'b0;
        In_Valid  = 1'b0;
        Hold      = 1'b0;
        In_Data   = '0;
        last_vec  = '0;
        #12;
        chk("rst_outputs", Outputs, 0);
        chk("rst_out_en", Out_EN, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_in_ready", In_Ready, 1);
        ASYNC_RST = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            load_tile(tc[i].base, tc[i].throttle);
            drain_check(tc[i].hold_after, tc[i].hold_len, tc[i].exp_done, tc[i].junk);
        end

        // Async reset after the third drained vector discards the tile.
        load_tile(30, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("pre_rst_en", Out_EN, 1);
            pop_check("pre_rst_data");
        end
        ASYNC_RST = 1'b0;
        #1;
        chk("arst_outputs", Outputs, 0);
        chk("arst_out_en", Out_EN, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_done", Done, 0);
        chk("arst_in_ready", In_Ready, 1);
        exp_q.delete();
        #1;
        ASYNC_RST = 1'b1;
        load_tile(60, 1'b0);
        drain_check(0, 0, 10, 1'b0);

        // Sync reset on the edge of an accepted beat drops the beat and the partial tile.
        In_Valid = 1'b1;
        for (int r = 0; r < 2; r++) begin
            In_Data = row_vec(90, r);
            step();
        end
        SYNC_RST = 1'b1;
        In_Data  = row_vec(90, 2);
        step();
        SYNC_RST = 1'b0;
        In_Valid = 1'b0;
        chk("srst_busy", Busy, 0);
        chk("srst_in_ready", In_Ready, 1);
        load_tile(140, 1'b0);
        drain_check(0, 0, 10, 1'b0);

        // Sync reset mid-drain.
        load_tile(10, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            pop_check("pre_srst_data");
        end
        SYNC_RST = 1'b1;
        step();
        SYNC_RST = 1'b0;
        chk("srst_drain_outputs", Outputs, 0);
        chk("srst_drain_out_en", Out_EN, 0);
        chk("srst_drain_busy", Busy, 0);
        chk("srst_drain_in_ready", In_Ready, 1);
        exp_q.delete();
        load_tile(170, 1'b1);
        drain_check(1, 2, 12, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_tile_feeder.md
# systolic_tile_feeder

Tile buffer and sequencer directly upstream of the systolic data-setup (skew) stage. It accepts one LENGTH x LENGTH operand tile as LENGTH vector beats over a valid/ready handshake and stores the tile locally. It then streams the tile one vector per cycle into the skew stage, followed by LENGTH-1 zero vectors so the skewed wavefront fully exits. Outputs and Out_EN drive the skew stage's Inputs and EN directly.

## Interface
- WIDTH, 8, bit width of one tile element
- LENGTH, 5, tile dimension and vector lane count; legal range 2..64
- CLK  input  1  clock, all state updates on rising edge
- ASYNC_RST  input  1  asynchronous, active-low reset
- SYNC_RST  input  1  synchronous, active-high reset; same effect as ASYNC_RST, applied at the clock edge
- In_Valid  input  1  In_Data holds a valid tile vector
- In_Ready  output  1  feeder accepts a beat; combinational, = (state == LOAD)
- In_Data  input  WIDTH x [0:LENGTH-1]  one tile vector per beat
- Hold  input  1  stall request from the array controller; freezes DRAIN/FLUSH
- Outputs  output  WIDTH x [0:LENGTH-1]  registered vector to the skew stage
- Out_EN  output  1  registered; skew stage samples Outputs when high
- Busy  output  1  registered; high in DRAIN, FLUSH and DONE
- Done  output  1  registered; single-cycle pulse at end of tile

## Operation
- Storage: buf[r][c], r = beat index, c = lane.
- Beat counter: $clog2(LENGTH)+1 bits.
- States: LOAD -> DRAIN -> FLUSH -> DONE -> LOAD. Reset state is LOAD.
- LOAD:
  - A beat is accepted on an edge with In_Valid && In_Ready: buf[cnt][*] <= In_Data, cnt++.
  - On the edge accepting beat LENGTH-1: go to DRAIN, cnt <= 0.
  - Hold is ignored.
- DRAIN:
  - Each edge with Hold=0: Outputs[i] <= buf[cnt][i], Out_EN <= 1, cnt++.
  - After LENGTH such edges: go to FLUSH, cnt <= 0.
- FLUSH:
  - Each edge with Hold=0: Outputs <= all zero, Out_EN <= 1, cnt++.
  - After LENGTH-1 such edges: go to DONE.
- Hold=1 on a DRAIN/FLUSH edge: Out_EN <= 0; Outputs, cnt and state unchanged.
- DONE: for one cycle, Out_EN <= 0, Done <= 1, Outputs <= 0. Next edge: LOAD, cnt <= 0, Done <= 0.
- In_Ready=0 outside LOAD, so In_Valid there is ignored and no beat is consumed.
- Per tile, Out_EN is high for exactly 2*LENGTH-1 unheld cycles.
- No arithmetic is performed on data; values pass through bit-exact.

## Timing
- Reset values:
  - Outputs = 0, Out_EN = 0, Busy = 0, Done = 0, cnt = 0, state = LOAD.
  - In_Ready = 1 after reset.
  - Buffer contents are not cleared.
- Latency:
  - Edge E accepts the last beat.
  - vec0 is visible on Outputs with Out_EN=1 after edge E+1, given Hold=0.
  - The last zero vector is visible after edge E+2*LENGTH-1.
  - Done is high after edge E+2*LENGTH.
  - In_Ready returns high after edge E+2*LENGTH+1.
- Back-to-back loads with In_Valid held high accept one beat per cycle with no bubbles.
- Reset mid-operation (either reset, any state): all outputs return to reset values at once (async) or at the edge (sync). A partially loaded or drained tile is discarded.
- SYNC_RST and an accepted beat on the same edge: reset wins and the beat is dropped.
- Hold asserted on the edge that would leave DRAIN or FLUSH: the transition is deferred until the first unheld edge.

## Configuration
- TRANSPOSE_EN defined: DRAIN emits columns, Outputs[i] <= buf[i][cnt], so the tile is fed transposed (weight-stationary layout).
- TRANSPOSE_EN undefined: DRAIN emits rows, Outputs[i] <= buf[cnt][i].
- All other behaviour and timing are identical in both builds.

## Test plan
All scenarios use LENGTH=5, WIDTH=8.

- Basic tile:
  - Stimulus: reset, then load rows r with element value 10*r+c back-to-back.
  - Response: Outputs show 0..4, 10..14, …, 40..44, then 4 zero vectors. Out_EN high for exactly 9 consecutive cycles, then Done=1 for one cycle, then In_Ready=1.
- Throttled input:
  - Stimulus: In_Valid toggles 1,0,1,0,…
  - Response: exactly 5 beats stored, DRAIN starts one edge after the 5th accepted beat, data identical to the basic case.
- Hold:
  - Stimulus: Hold=1 for 3 cycles after the 2nd DRAIN vector.
  - Response: Out_EN=0 for those 3 cycles with Outputs held at row 1. Stream resumes with row 2. Total Out_EN-high cycles still 9.
- Ignored input:
  - Stimulus: In_Valid=1 with data 0xFF during DRAIN.
  - Response: In_Ready=0 and the buffer is unchanged. The next tile loads correctly after Done.
- Reset mid-drain:
  - Stimulus: ASYNC_RST pulsed low after the 3rd DRAIN vector.
  - Response: Outputs=0, Out_EN=0, Busy=0 immediately, In_Ready=1. The next tile streams from its row 0.
- TRANSPOSE_EN build:
  - Stimulus: same data as the basic tile.
  - Response: first vector is 0,10,20,30,40 and the last data vector is 4,14,24,34,44.
